// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned STRB_W = 4;

  localparam logic [ADDR_W-1:0] KSEG_MASK = 32'h1FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D_ADDR = 3'd1,
    ST_D_DATA = 3'd2,
    ST_I_ADDR = 3'd3,
    ST_I_DATA = 3'd4
  } state_e;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // kseg0 and kseg1 together span 0x8000_0000..0xBFFF_FFFF.
  function automatic logic is_kseg01(input logic [ADDR_W-1:0] vaddr);
    return vaddr[ADDR_W-1 -: 2] == 2'b10;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_addr_map.sv
// Combinational virtual-to-physical translation for the unmapped kernel segments.
module mem_port_arbiter_addr_map
  import mem_port_arbiter_pkg::*;
#(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic [ADDR_W-1:0] vaddr_i,
  output logic [ADDR_W-1:0] paddr_o
);

  always_comb begin
    paddr_o = vaddr_i;
    if (KSEG_MAP && is_kseg01(vaddr_i)) begin
      paddr_o = vaddr_i & KSEG_MASK;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like bus port between instruction fetch and MEM-stage load/store,
// holding each result until the pipeline advances.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter bit KSEG_MAP   = 1'b1,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pipe_adv_i,
  input  logic              if_flush_i,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              stallreq_from_if_o,
  input  logic              data_en_i,
  input  logic              data_we_i,
  input  logic [SIZE_W-1:0] data_size_i,
  input  logic [STRB_W-1:0] data_sel_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              stallreq_from_mem_o,
  output logic              bus_req_o,
  output logic              bus_wr_o,
  output logic [SIZE_W-1:0] bus_size_o,
  output logic [STRB_W-1:0] bus_wstrb_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_addr_ok_i,
  input  logic              bus_data_ok_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  state_e            state_q;
  bus_cmd_t          cmd_q;
  bus_cmd_t          cmd_d;
  logic              bus_req_q;
  logic              drop_q;
  logic              inst_vld_q;
  logic              data_vld_q;
  logic [DATA_W-1:0] inst_buf_q;
  logic [DATA_W-1:0] data_buf_q;

  logic              dreq;
  logic              ireq;
  logic              pick_data;
  logic [ADDR_W-1:0] vaddr_mux;
  logic [ADDR_W-1:0] paddr;

  assign dreq      = data_en_i & ~data_vld_q;
  assign ireq      = inst_req_i & ~inst_vld_q & ~if_flush_i;
  assign pick_data = dreq & (DATA_FIRST | ~ireq);
  assign vaddr_mux = pick_data ? data_addr_i : inst_addr_i;

  mem_port_arbiter_addr_map #(
    .KSEG_MAP(KSEG_MAP)
  ) u_addr_map (
    .vaddr_i(vaddr_mux),
    .paddr_o(paddr)
  );

  // Command captured on leaving IDLE; fetches are always word reads.
  always_comb begin
    cmd_d      = '0;
    cmd_d.addr = paddr;
    cmd_d.size = SIZE_W'(SIZE_WORD);
    if (pick_data) begin
      cmd_d.wr    = data_we_i;
      cmd_d.size  = data_size_i;
      cmd_d.wstrb = data_we_i ? data_sel_i : STRB_W'(0);
      cmd_d.wdata = data_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      bus_req_q  <= 1'b0;
      drop_q     <= 1'b0;
      inst_vld_q <= 1'b0;
      data_vld_q <= 1'b0;
      inst_buf_q <= '0;
      data_buf_q <= '0;
    end else begin
      if (pipe_adv_i) begin
        inst_vld_q <= 1'b0;
        data_vld_q <= 1'b0;
      end
      if (if_flush_i) begin
        inst_vld_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (dreq || ireq) begin
            cmd_q     <= cmd_d;
            bus_req_q <= 1'b1;
            state_q   <= pick_data ? ST_D_ADDR : ST_I_ADDR;
          end
        end
        ST_D_ADDR: begin
          if (bus_addr_ok_i) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_D_DATA;
          end
        end
        ST_D_DATA: begin
          if (bus_data_ok_i) begin
            data_buf_q <= bus_rdata_i;
            data_vld_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        // A flushed fetch still runs to completion on the bus; only its data is dropped.
        ST_I_ADDR: begin
          if (if_flush_i) begin
            drop_q <= 1'b1;
          end
          if (bus_addr_ok_i) begin
            bus_req_q <= 1'b0;
            state_q   <= ST_I_DATA;
          end
        end
        ST_I_DATA: begin
          if (if_flush_i) begin
            drop_q <= 1'b1;
          end
          if (bus_data_ok_i) begin
            drop_q  <= 1'b0;
            state_q <= ST_IDLE;
            if (!drop_q && !if_flush_i) begin
              inst_buf_q <= bus_rdata_i;
              inst_vld_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign stallreq_from_if_o  = inst_req_i & ~inst_vld_q;
  assign stallreq_from_mem_o = data_en_i & ~data_vld_q;
  assign inst_rdata_o        = inst_buf_q;
  assign data_rdata_o        = data_buf_q;
  assign bus_req_o           = bus_req_q;
  assign bus_wr_o            = cmd_q.wr;
  assign bus_size_o          = cmd_q.size;
  assign bus_wstrb_o         = cmd_q.wstrb;
  assign bus_addr_o          = cmd_q.addr;
  assign bus_wdata_o         = cmd_q.wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-by-cycle bench for mem_port_arbiter; the bench plays the bus slave.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_adv;
  logic        if_flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        stall_if;
  logic        data_en;
  logic        data_we;
  logic [1:0]  data_size;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        stall_mem;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .KSEG_MAP  (1'b1),
    .DATA_FIRST(1'b1)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .pipe_adv_i         (pipe_adv),
    .if_flush_i         (if_flush),
    .inst_req_i         (inst_req),
    .inst_addr_i        (inst_addr),
    .inst_rdata_o       (inst_rdata),
    .stallreq_from_if_o (stall_if),
    .data_en_i          (data_en),
    .data_we_i          (data_we),
    .data_size_i        (data_size),
    .data_sel_i         (data_sel),
    .data_addr_i        (data_addr),
    .data_wdata_i       (data_wdata),
    .data_rdata_o       (data_rdata),
    .stallreq_from_mem_o(stall_mem),
    .bus_req_o          (bus_req),
    .bus_wr_o           (bus_wr),
    .bus_size_o         (bus_size),
    .bus_wstrb_o        (bus_wstrb),
    .bus_addr_o         (bus_addr),
    .bus_wdata_o        (bus_wdata),
    .bus_addr_ok_i      (bus_addr_ok),
    .bus_data_ok_i      (bus_data_ok),
    .bus_rdata_i        (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; pipe_adv = 1'b0; if_flush = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_en = 1'b0; data_we = 1'b0; data_size = 2'd0; data_sel = 4'h0;
    data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    to_pos(); to_pos();
    to_neg();
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_stall_if", 32'(stall_if), 32'd0);
    chk("rst_stall_mem", 32'(stall_mem), 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'h0);
    to_pos();
    rst = 1'b0;

    // Lone kseg1 fetch, zero-wait slave
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    to_neg();
    chk("t1_stall_c0", 32'(stall_if), 32'd1);
    chk("t1_req_c0", 32'(bus_req), 32'd0);
    to_pos();
    bus_addr_ok = 1'b1;
    to_neg();
    chk("t1_req_c1", 32'(bus_req), 32'd1);
    chk("t1_addr", bus_addr, 32'h1FC0_0000);
    chk("t1_size", 32'(bus_size), 32'd2);
    chk("t1_wr", 32'(bus_wr), 32'd0);
    chk("t1_stall_c1", 32'(stall_if), 32'd1);
    to_pos();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001;
    to_neg();
    chk("t1_req_c2", 32'(bus_req), 32'd0);
    chk("t1_stall_c2", 32'(stall_if), 32'd1);
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t1_stall_c3", 32'(stall_if), 32'd0);
    chk("t1_rdata", inst_rdata, 32'h2408_0001);
    pipe_adv = 1'b1; inst_req = 1'b0;
    to_pos();
    pipe_adv = 1'b0;

    // Same-cycle fetch and load: data goes first
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_en = 1'b1; data_we = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0010;
    to_neg();
    chk("t2_stall_if_c0", 32'(stall_if), 32'd1);
    chk("t2_stall_mem_c0", 32'(stall_mem), 32'd1);
    to_pos();
    bus_addr_ok = 1'b1;
    to_neg();
    chk("t2_req_c1", 32'(bus_req), 32'd1);
    chk("t2_daddr", bus_addr, 32'h0000_0010);
    chk("t2_dwr", 32'(bus_wr), 32'd0);
    chk("t2_dstrb", 32'(bus_wstrb), 32'd0);
    to_pos();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
    to_neg();
    chk("t2_req_c2", 32'(bus_req), 32'd0);
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t2_stall_mem_c3", 32'(stall_mem), 32'd0);
    chk("t2_drdata", data_rdata, 32'h1111_2222);
    chk("t2_stall_if_c3", 32'(stall_if), 32'd1);
    chk("t2_req_c3", 32'(bus_req), 32'd0);
    to_pos();
    bus_addr_ok = 1'b1;
    to_neg();
    chk("t2_req_c4", 32'(bus_req), 32'd1);
    chk("t2_iaddr", bus_addr, 32'h1FC0_0004);
    to_pos();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h3C1D_BFC0;
    to_neg();
    chk("t2_stall_if_c5", 32'(stall_if), 32'd1);
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t2_stall_if_c6", 32'(stall_if), 32'd0);
    chk("t2_stall_mem_c6", 32'(stall_mem), 32'd0);
    chk("t2_irdata", inst_rdata, 32'h3C1D_BFC0);
    pipe_adv = 1'b1; inst_req = 1'b0; data_en = 1'b0;
    to_pos();
    pipe_adv = 1'b0;

    // Byte store into kseg0
    data_en = 1'b1; data_we = 1'b1; data_size = 2'd0; data_sel = 4'b1000;
    data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
    to_neg();
    chk("t3_stall_c0", 32'(stall_mem), 32'd1);
    to_pos();
    bus_addr_ok = 1'b1;
    to_neg();
    chk("t3_req", 32'(bus_req), 32'd1);
    chk("t3_wr", 32'(bus_wr), 32'd1);
    chk("t3_wstrb", 32'(bus_wstrb), 32'h8);
    chk("t3_addr", bus_addr, 32'h0000_0003);
    chk("t3_wdata", bus_wdata, 32'hAB00_0000);
    chk("t3_size", 32'(bus_size), 32'd0);
    to_pos();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0;
    to_neg();
    chk("t3_stall_c2", 32'(stall_mem), 32'd1);
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t3_stall_c3", 32'(stall_mem), 32'd0);
    pipe_adv = 1'b1; data_en = 1'b0; data_we = 1'b0; data_sel = 4'h0;
    to_pos();
    pipe_adv = 1'b0;

    // Flush while the fetch waits for data
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    to_pos();
    bus_addr_ok = 1'b1;
    to_neg();
    chk("t4_req_c1", 32'(bus_req), 32'd1);
    to_pos();
    bus_addr_ok = 1'b0; if_flush = 1'b1; inst_addr = 32'h0040_0000;
    to_neg();
    chk("t4_req_c2", 32'(bus_req), 32'd0);
    chk("t4_stall_c2", 32'(stall_if), 32'd1);
    to_pos();
    if_flush = 1'b0;
    to_neg();
    chk("t4_req_c3", 32'(bus_req), 32'd0);
    to_pos();
    bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    to_neg();
    chk("t4_stall_c4", 32'(stall_if), 32'd1);
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t4_stall_c5", 32'(stall_if), 32'd1);
    chk("t4_dropped", inst_rdata, 32'h3C1D_BFC0);
    chk("t4_req_c5", 32'(bus_req), 32'd0);
    to_pos();
    bus_addr_ok = 1'b1;
    to_neg();
    chk("t4_req_c6", 32'(bus_req), 32'd1);
    chk("t4_addr", bus_addr, 32'h0040_0000);
    to_pos();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h8FA4_0000;
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t4_stall_c8", 32'(stall_if), 32'd0);
    chk("t4_rdata", inst_rdata, 32'h8FA4_0000);
    pipe_adv = 1'b1; inst_req = 1'b0;
    to_pos();
    pipe_adv = 1'b0;

    // Fetch result held while a slow load completes
    inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
    to_pos();
    bus_addr_ok = 1'b1;
    to_pos();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h27BD_FFE8;
    data_en = 1'b1; data_we = 1'b0; data_size = 2'd2; data_addr = 32'h8000_0040;
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t5_stall_if_c3", 32'(stall_if), 32'd0);
    chk("t5_stall_mem_c3", 32'(stall_mem), 32'd1);
    chk("t5_irdata_c3", inst_rdata, 32'h27BD_FFE8);
    to_pos();
    bus_addr_ok = 1'b1;
    to_neg();
    chk("t5_req_c4", 32'(bus_req), 32'd1);
    chk("t5_addr", bus_addr, 32'h0000_0040);
    to_pos();
    bus_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("t5_wait_req", 32'(bus_req), 32'd0);
      chk("t5_wait_stall_mem", 32'(stall_mem), 32'd1);
      to_pos();
    end
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t5_stall_mem_done", 32'(stall_mem), 32'd0);
    chk("t5_stall_if_done", 32'(stall_if), 32'd0);
    chk("t5_drdata", data_rdata, 32'hCAFE_F00D);
    chk("t5_irdata_held", inst_rdata, 32'h27BD_FFE8);
    to_pos();
    to_neg();
    chk("t5_no_refetch", 32'(bus_req), 32'd0);
    chk("t5_hold_if", 32'(stall_if), 32'd0);
    pipe_adv = 1'b1; inst_req = 1'b0; data_en = 1'b0;
    to_pos();
    pipe_adv = 1'b0;
    inst_req = 1'b1; if_flush = 1'b1;
    to_neg();
    chk("t5_buf_cleared", 32'(stall_if), 32'd1);
    inst_req = 1'b0; if_flush = 1'b0;
    to_pos();

    // Reset while a load waits for addr_ok
    data_en = 1'b1; data_addr = 32'h8000_0050;
    to_pos();
    to_neg();
    chk("t6_req_before", 32'(bus_req), 32'd1);
    rst = 1'b1; data_en = 1'b0;
    to_pos();
    rst = 1'b0;
    to_neg();
    chk("t6_req_after", 32'(bus_req), 32'd0);
    chk("t6_stall_if", 32'(stall_if), 32'd0);
    chk("t6_stall_mem", 32'(stall_mem), 32'd0);
    chk("t6_drdata", data_rdata, 32'h0);
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    to_pos();
    bus_addr_ok = 1'b1;
    to_neg();
    chk("t6_idle_issue", 32'(bus_req), 32'd1);
    chk("t6_idle_addr", bus_addr, 32'h0000_0100);
    to_pos();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_F00D;
    to_pos();
    bus_data_ok = 1'b0;
    to_neg();
    chk("t6_stall_done", 32'(stall_if), 32'd0);
    chk("t6_irdata", inst_rdata, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
